// File: rtl/fixed_pkg.sv
// Shared Q16.16 fixed-point types, constants and accumulator FSM state encoding.
package fixed_pkg;

  typedef logic signed [31:0] q16_16_t;

  localparam q16_16_t Q_MAX = 32'h7FFF_FFFF;
  localparam q16_16_t Q_MIN = 32'h8000_0000;
  localparam q16_16_t Q_ONE = 32'h0001_0000;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/fixed_32_block_accum_if.sv
// Sample-in / block-result-out handshake bundle for fixed_32_block_accum.
interface fixed_32_block_accum_if
  import fixed_pkg::*;
#(
  parameter int unsigned BLOCK_LEN = 8
);
  localparam int unsigned CNT_W = $clog2(BLOCK_LEN + 1);

  logic             in_valid;
  logic             in_ready;
  q16_16_t          in_data;
  logic             in_sub;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  q16_16_t          out_data;
  logic             out_overflow;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_sub, flush, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, out_count
  );

  modport slave (
    input  in_valid, in_data, in_sub, flush, out_ready,
    output in_ready, out_valid, out_data, out_overflow, out_count
  );

endinterface

// File: rtl/fixed_32_sat_add.sv
// Combinational Q16.16 add/sub with overflow detect.
// Define FIXED_ACC_SATURATE_EN to clamp overflowing results instead of wrapping.
module fixed_32_sat_add
  import fixed_pkg::*;
(
  input  q16_16_t a,
  input  q16_16_t b,
  input  logic    sub,
  output q16_16_t result,
  output logic    overflow
);

  logic [32:0] wide;

  always_comb begin
    wide     = sub ? ({a[31], a} - {b[31], b}) : ({a[31], a} + {b[31], b});
    overflow = wide[32] ^ wide[31];
`ifdef FIXED_ACC_SATURATE_EN
    // wide[32] is the true sign of the unbounded result
    if (overflow) begin
      result = wide[32] ? Q_MIN : Q_MAX;
    end else begin
      result = wide[31:0];
    end
`else
    result = wide[31:0];
`endif
  end

endmodule

// File: rtl/fixed_32_block_accum.sv
// Streaming Q16.16 block accumulator: sums BLOCK_LEN signed samples (or fewer on flush)
// and presents one registered result with sticky overflow. Saturation: FIXED_ACC_SATURATE_EN.
module fixed_32_block_accum
  import fixed_pkg::*;
#(
  parameter int unsigned BLOCK_LEN = 8
)(
  input  logic                    clk,
  input  logic                    rst,
  fixed_32_block_accum_if.slave   bus
);

  localparam int unsigned       CNT_W    = $clog2(BLOCK_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  acc_state_e       state_q, state_d;
  q16_16_t          acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  q16_16_t          out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic             in_ready;
  logic             beat;
  logic             last_beat;
  logic             early_flush;
  q16_16_t          sum;
  logic             add_ovf;

  fixed_32_sat_add u_add (
    .a        (acc_q),
    .b        (bus.in_data),
    .sub      (bus.in_sub),
    .result   (sum),
    .overflow (add_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (last_beat || early_flush) state_d = HOLD;
      HOLD:    if (bus.out_ready)            state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ACCUM);
  end

  assign beat        = bus.in_valid && in_ready;
  assign last_beat   = beat && ((cnt_q == LAST_CNT) || bus.flush);
  // a flush with no beat only closes a block that already holds samples
  assign early_flush = in_ready && !bus.in_valid && bus.flush && (cnt_q != '0);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_cnt_d   = out_cnt_q;

    if (last_beat) begin
      out_data_d  = sum;
      out_ovf_d   = ovf_q | add_ovf;
      out_cnt_d   = cnt_q + CNT_ONE;
      out_valid_d = 1'b1;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
    end else if (beat) begin
      acc_d = sum;
      cnt_d = cnt_q + CNT_ONE;
      ovf_d = ovf_q | add_ovf;
    end else if (early_flush) begin
      out_data_d  = acc_q;
      out_ovf_d   = ovf_q;
      out_cnt_d   = cnt_q;
      out_valid_d = 1'b1;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
    end

    if (state_q == HOLD && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_overflow = out_ovf_q;
  assign bus.out_count    = out_cnt_q;

endmodule

// File: tb/tb_fixed_32_block_accum.sv
// Self-checking bench for fixed_32_block_accum (BLOCK_LEN=4) against an arithmetic reference model.
module tb_fixed_32_block_accum;

  localparam int unsigned BL = 4;

  logic clk = 1'b0;
  logic rst;

  fixed_32_block_accum_if #(.BLOCK_LEN(BL)) bus ();

  fixed_32_block_accum #(.BLOCK_LEN(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // reference model: running sum as plain integers, result as last emitted block
  int          m_sum;
  int unsigned m_cnt;
  bit          m_ovf;
  bit          m_pending;
  int          m_out_data;
  bit          m_out_ovf;
  int unsigned m_out_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_ovf = 0; m_pending = 0;
    m_out_data = 0; m_out_ovf = 0; m_out_cnt = 0;
  endtask

  task automatic model_emit();
    m_out_data = m_sum;
    m_out_ovf  = m_ovf;
    m_out_cnt  = m_cnt;
    m_pending  = 1;
    m_sum = 0; m_cnt = 0; m_ovf = 0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] d, input logic s,
                            input logic fl, input logic ordy);
    longint w;
    logic [63:0] wb;
    bit o;
    if (m_pending) begin
      if (ordy) m_pending = 0;
    end else if (v) begin
      w = longint'(m_sum) + (s ? -longint'(int'(d)) : longint'(int'(d)));
      o = (w > 64'sd2147483647) || (w < -64'sd2147483648);
`ifdef FIXED_ACC_SATURATE_EN
      if (w > 64'sd2147483647)       m_sum = 32'h7FFF_FFFF;
      else if (w < -64'sd2147483648) m_sum = 32'h8000_0000;
      else                           m_sum = int'(w);
`else
      wb    = w;
      m_sum = int'(wb[31:0]);
`endif
      m_cnt++;
      m_ovf = m_ovf | o;
      if (m_cnt == BL || fl) model_emit();
    end else if (fl && m_cnt > 0) begin
      model_emit();
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"},    32'(bus.out_valid),    32'(m_pending));
    chk({tag, ".out_data"},     bus.out_data,          m_out_data);
    chk({tag, ".out_overflow"}, 32'(bus.out_overflow), 32'(m_out_ovf));
    chk({tag, ".out_count"},    32'(bus.out_count),    m_out_cnt);
  endtask

  // one clock cycle: drive, check in_ready, advance model, check registered outputs
  task automatic cyc(input logic v, input logic [31:0] d, input logic s,
                     input logic fl, input logic ordy, input string tag);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_sub    = s;
    bus.flush     = fl;
    bus.out_ready = ordy;
    #1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(!m_pending));
    model_step(v, d, s, fl, ordy);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input logic ordy, input string tag);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, ordy, tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] held;
    model_reset();
    rst = 1'b1;
    bus.in_valid = 0; bus.in_data = '0; bus.in_sub = 0; bus.flush = 0; bus.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;

    // four beats of +1.0, result exactly one cycle after the 4th beat
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0, "plus1");
    chk("plus1.const_data",  bus.out_data,         32'h0004_0000);
    chk("plus1.const_count", 32'(bus.out_count),   32'd4);
    chk("plus1.const_ovf",   32'(bus.out_overflow), 32'd0);
    idle(1'b1, "plus1.release");

    // 2.5 - 0.75 + (-1.0) - (-0.25) = 1.0
    cyc(1'b1, 32'h0002_8000, 1'b0, 1'b0, 1'b1, "mix");
    cyc(1'b1, 32'h0000_C000, 1'b1, 1'b0, 1'b1, "mix");
    cyc(1'b1, 32'hFFFF_0000, 1'b0, 1'b0, 1'b1, "mix");
    cyc(1'b1, 32'hFFFF_C000, 1'b1, 1'b0, 1'b1, "mix");
    chk("mix.const_data", bus.out_data,          32'h0001_0000);
    chk("mix.const_ovf",  32'(bus.out_overflow), 32'd0);
    idle(1'b1, "mix.release");

    // positive overflow
    cyc(1'b1, 32'h7FFF_0000, 1'b0, 1'b0, 1'b0, "ovf");
    cyc(1'b1, 32'h0002_0000, 1'b0, 1'b0, 1'b0, "ovf");
    cyc(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, "ovf");
    cyc(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, "ovf");
    chk("ovf.const_ovf", 32'(bus.out_overflow), 32'd1);
`ifdef FIXED_ACC_SATURATE_EN
    chk("ovf.const_data", bus.out_data, 32'h7FFF_FFFF);
`else
    chk("ovf.const_data", bus.out_data, 32'h8001_0000);
`endif

    // backpressure: result held 5 cycles, offered samples refused
    held = bus.out_data;
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0, "hold");
    chk("hold.const_data", bus.out_data, held);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "hold.release");
    chk("hold.valid_low", 32'(bus.out_valid), 32'd0);
    idle(1'b0, "hold.ready_back");

    // early flush after two beats
    cyc(1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b1, "flush2");
    cyc(1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b1, "flush2");
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "flush2");
    chk("flush2.const_data",  bus.out_data,       32'h0002_0000);
    chk("flush2.const_count", 32'(bus.out_count), 32'd2);
    idle(1'b1, "flush2.release");

    // flush on an empty block is ignored
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, "flush0");
    chk("flush0.no_valid", 32'(bus.out_valid), 32'd0);

    // flush coinciding with a beat includes that beat
    cyc(1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0, "flushbeat");
    cyc(1'b1, 32'h0003_0000, 1'b0, 1'b1, 1'b0, "flushbeat");
    chk("flushbeat.const_data",  bus.out_data,       32'h0004_0000);
    chk("flushbeat.const_count", 32'(bus.out_count), 32'd2);

    // reset while a result is pending, then mid-block
    async_reset("rst_hold");
    cyc(1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b1, "rst_mid");
    cyc(1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b1, "rst_mid");
    async_reset("rst_mid.reset");
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0, "rst_after");
    chk("rst_after.const_data", bus.out_data, 32'h0004_0000);
    idle(1'b1, "rst_after.release");

    // randomized traffic, including near-full-scale values to exercise overflow
    for (int i = 0; i < 500; i++) begin
      rd = $urandom;
      if ($urandom_range(3) != 0) rd = {{12{rd[31]}}, rd[19:0]};
      cyc(1'($urandom_range(3) != 0), rd, 1'($urandom_range(1)),
          1'($urandom_range(9) == 0), 1'($urandom_range(2) != 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fixed_32_block_accum.md
# fixed_32_block_accum

Streaming Q16.16 block accumulator that sits directly downstream of the 32-bit fixed-point add/sub datapath. It accepts signed Q16.16 samples over a valid/ready handshake and adds or subtracts each one into a running sum. After BLOCK_LEN samples, or on an early flush, it emits the block result with a sticky overflow flag and a sample count. It is the first sequential stage consuming add/sub results in the fixed-point pipeline.

## Interface
- BLOCK_LEN, 8: samples per block; legal range 1..65535.
- CNT_W, $clog2(BLOCK_LEN+1): sample-count width; derived, never overridden.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  in_data/in_sub valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  32  signed Q16.16 sample.
- in_sub  input  1  1: sum -= in_data; 0: sum += in_data.
- flush  input  1  close the current block early.
- out_valid  output  1  block result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  signed Q16.16 block result.
- out_overflow  output  1  set if any operation in the block overflowed.
- out_count  output  CNT_W  samples contained in this block.

## Operation
- FSM states: ACCUM and HOLD. Reset state is ACCUM.
- Internal state:
  - acc: 32-bit running sum.
  - cnt: CNT_W-bit sample counter.
  - ovf: sticky overflow flag.
- Reset values:
  - acc=0, cnt=0, ovf=0.
  - out_valid=0, out_data=0, out_overflow=0, out_count=0.
- in_ready = (state==ACCUM). It is decoded from state only and never depends on out_ready.
- Beat: a cycle with in_valid && in_ready.
- Arithmetic on a beat:
  - Sign-extend acc and in_data to 33 bits.
  - Compute wide = acc ± in_data.
  - Overflow when wide[32] != wide[31].
  - Without overflow, the new sum is wide[31:0].
  - With overflow, see Configuration.
- Beat with cnt != BLOCK_LEN-1 and flush=0: acc <= new sum, cnt++, ovf |= overflow.
- Last beat (beat with cnt==BLOCK_LEN-1, or beat with flush=1):
  - out_data <= new sum, out_overflow <= ovf | overflow, out_count <= cnt+1, out_valid <= 1.
  - acc, cnt, ovf cleared; state <= HOLD.
- Flush without a beat in ACCUM:
  - If cnt>0: emit out_data=acc, out_overflow=ovf, out_count=cnt; clear acc/cnt/ovf; go to HOLD.
  - If cnt==0: ignored, no output.
- HOLD:
  - When out_ready=1: out_valid <= 0, state <= ACCUM.
  - Otherwise out_data, out_overflow and out_count hold stable.
  - flush and in_valid are ignored in HOLD.
- BLOCK_LEN=1: every beat is a last beat.
- Reset asserted mid-block or mid-HOLD: any partial sum or pending result is discarded; all state returns to reset values immediately.

## Timing
- Result latency: out_valid rises on the first clk edge after the last beat, i.e. one cycle.
- Maximum throughput: one block per BLOCK_LEN+1 cycles when out_ready is held high, because HOLD lasts at least one cycle.
- out_data, out_overflow and out_count are registered, with no combinational path from the inputs.
- The only combinational output is in_ready, decoded from state.

## Configuration
- FIXED_ACC_SATURATE_EN defined:
  - An overflowing result clamps to 0x7FFF_FFFF if wide[32]==0, otherwise to 0x8000_0000.
  - Accumulation continues from the clamped value.
- FIXED_ACC_SATURATE_EN undefined: the result wraps to wide[31:0].
- In both cases the overflow flag is set identically.

## Structure
- Shared package fixed_pkg holds:
  - the q16_16_t typedef (logic signed [31:0]);
  - Q_MAX=32'h7FFF_FFFF, Q_MIN=32'h8000_0000, Q_ONE=32'h0001_0000;
  - the accumulator state enum.
- One sub-module, fixed_32_sat_add:
  - Combinational 33-bit sign-extended add/sub.
  - Inputs a, b, sub. Outputs result and overflow.
  - Saturation is under FIXED_ACC_SATURATE_EN.
- The FSM, counter and output registers live in the top module.

## Test plan
- BLOCK_LEN=4, four beats adding 0x0001_0000 -> out_data=0x0004_0000, out_count=4, out_overflow=0; out_valid high exactly one cycle after the 4th beat.
- BLOCK_LEN=4, beats +0x0002_8000, sub 0x0000_C000, +0xFFFF_0000, sub 0xFFFF_C000 (2.5-0.75-1.0+0.25) -> out_data=0x0001_0000, out_overflow=0.
- BLOCK_LEN=4, beats +0x7FFF_0000, +0x0002_0000, +0, +0 -> out_overflow=1; out_data=0x7FFF_FFFF with FIXED_ACC_SATURATE_EN, 0x8001_0000 without.
- Result presented with out_ready held low 5 cycles -> out_data stable, in_ready=0, in_valid beats not absorbed; out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Flush:
  - Two beats of +0x0001_0000, then flush -> out_data=0x0002_0000, out_count=2.
  - Flush with cnt=0 -> no out_valid.
  - Flush coinciding with a beat -> that beat is included.
- Reset mid-block:
  - rst pulsed after 2 beats -> all outputs return to 0 immediately.
  - A following 4-beat block of +0x0001_0000 yields 0x0004_0000.
